// File: rtl/wait_event_pkg.sv
// wait_event_pkg: shared modes, states and helpers for the testbench wait blocks
package wait_event_pkg;
  typedef enum logic [2:0] {WTR, WTF, WTE, WUH, WUL} wait_mode_t;
  typedef enum logic {IDLE, ARMED} wait_state_t;
  function automatic logic is_legal_mode(input logic [2:0] m);
    return m <= 3'd4;
  endfunction
  function automatic logic [31:0] occ_eff(input logic [31:0] occ);
    return occ == '0 ? 32'd1 : occ;
  endfunction
endpackage

// File: rtl/wait_event_timer.sv
// wait_event_timer: saturating elapsed-cycle counter with a timeout compare
module wait_event_timer #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         en,
  input  logic [W-1:0] max,
  output logic [W-1:0] o_elapsed,
  output logic         o_expire
);
  logic [W-1:0] elapsed_q, elapsed_d;
  always_comb begin
    elapsed_d = clr ? '0 : (en && !(&elapsed_q)) ? elapsed_q + W'(1) : elapsed_q;
    o_expire  = en && (max != '0) && (elapsed_q == max - W'(1));
  end
  always_ff @(posedge clk) elapsed_q <= rst ? '0 : elapsed_d;
  assign o_elapsed = elapsed_q;
endmodule

// File: rtl/wait_multi_event_tb.sv
// wait_multi_event_tb: waits for N occurrences of an edge/level condition on one event line
module wait_multi_event_tb
  import wait_event_pkg::*;
#(
  parameter int WAIT_SIZE = 16,
  parameter int CNT_WIDTH = 8,
  parameter int TO_WIDTH  = 32
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         i_start,
  input  logic [$clog2(WAIT_SIZE)-1:0] i_sel,
  input  logic [2:0]                   i_mode,
  input  logic [CNT_WIDTH-1:0]         i_occ,
  input  logic [TO_WIDTH-1:0]          i_max_timeout,
  input  logic                         i_abort,
  input  logic [WAIT_SIZE-1:0]         i_wait,
  output logic                         o_busy,
  output logic                         o_done,
  output logic                         o_timeout,
  output logic                         o_err,
  output logic [CNT_WIDTH-1:0]         o_evt_cnt,
  output logic [TO_WIDTH-1:0]          o_elapsed
);
  localparam int SW = $clog2(WAIT_SIZE);
  wait_state_t          state_q, state_d;
  wait_mode_t           mode_q, mode_d;
  logic [SW-1:0]        sel_q, sel_d;
  logic [CNT_WIDTH-1:0] occ_q, occ_d, cnt_q, cnt_d;
  logic [TO_WIDTH-1:0]  max_q, max_d;
  logic [WAIT_SIZE-1:0] s_wait_q;
  logic done_q, done_d, tout_q, tout_d, err_q, err_d;
  logic armed, go, cur, prv, hit, complete, expire;
  wait_event_timer #(.W(TO_WIDTH)) u_timer (
    .clk(clk), .rst(rst), .clr(go), .en(armed), .max(max_q),
    .o_elapsed(o_elapsed), .o_expire(expire)
  );
  always_comb begin
    armed = state_q == ARMED;
    go    = !armed && i_start && is_legal_mode(i_mode);
    cur   = i_wait[sel_q];
    prv   = s_wait_q[sel_q];
    hit   = mode_q == WTR ? cur & ~prv :
            mode_q == WTF ? ~cur & prv :
            mode_q == WTE ? cur ^ prv  :
            mode_q == WUH ? cur        :
            mode_q == WUL ? ~cur       : 1'b0;
    complete = armed && ((32'(cnt_q) + 32'(hit)) >= occ_eff(32'(occ_q)));
    sel_d  = go ? i_sel : sel_q;
    mode_d = go ? wait_mode_t'(i_mode) : mode_q;
    occ_d  = go ? i_occ : occ_q;
    max_d  = go ? i_max_timeout : max_q;
    cnt_d  = go ? '0 : (armed && hit && !(&cnt_q)) ? cnt_q + CNT_WIDTH'(1) : cnt_q;
    // abort outranks both completion and timeout; completion outranks timeout
    done_d  = armed && !i_abort && (complete || expire);
    tout_d  = armed && !i_abort && expire && !complete;
    err_d   = i_start && (armed || !is_legal_mode(i_mode));
    state_d = armed ? ((i_abort || complete || expire) ? IDLE : ARMED) :
              go    ? ARMED : IDLE;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      mode_q   <= WTR;
      sel_q    <= '0;
      occ_q    <= '0;
      max_q    <= '0;
      cnt_q    <= '0;
      done_q   <= 1'b0;
      tout_q   <= 1'b0;
      err_q    <= 1'b0;
      s_wait_q <= '0;
    end else begin
      state_q  <= state_d;
      mode_q   <= mode_d;
      sel_q    <= sel_d;
      occ_q    <= occ_d;
      max_q    <= max_d;
      cnt_q    <= cnt_d;
      done_q   <= done_d;
      tout_q   <= tout_d;
      err_q    <= err_d;
      s_wait_q <= i_wait;
    end
  end
  assign o_busy    = state_q == ARMED;
  assign o_done    = done_q;
  assign o_timeout = tout_q;
  assign o_err     = err_q;
  assign o_evt_cnt = cnt_q;
endmodule
